// File: rtl/core_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : core_dmem_arbiter
//  Description : N-core data-memory arbiter onto one shared data bus with
//                round-robin or fixed-priority selection, per-core enable
//                masking and a bus timeout that returns an error to the core.
//  Revision    : 1.0  initial release
// ============================================================================
module core_dmem_arbiter #(
    parameter int NCORES  = 2,
    parameter int RW      = 16,
    parameter int SELW    = 2,
    parameter int RR      = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NCORES-1:0]      i_core_en,
    input  logic [NCORES-1:0]      i_req,
    input  logic [NCORES-1:0]      i_we,
    input  logic [NCORES*RW-1:0]   i_addr,
    input  logic [NCORES*RW-1:0]   i_wdata,
    input  logic [NCORES*SELW-1:0] i_sel,
    input  logic [NCORES-1:0]      i_long,
    input  logic [NCORES*8-1:0]    i_addr_high,
    output logic [NCORES-1:0]      o_ack,
    output logic [NCORES-1:0]      o_err,
    output logic [RW-1:0]          o_rdata,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [RW-1:0]          o_mem_addr,
    output logic [RW-1:0]          o_mem_data,
    output logic [SELW-1:0]        o_mem_sel,
    output logic                   o_mem_long,
    output logic [7:0]             o_mem_addr_high,
    input  logic                   i_mem_ack,
    input  logic                   i_mem_err,
    input  logic [RW-1:0]          i_mem_rdata
);

    localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NCORES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     grant, grant_nxt;
    logic [GW-1:0]     last, last_nxt;
    logic [GW-1:0]     pick;
    logic              found;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [NCORES-1:0] elig;

    logic [NCORES-1:0] ack_nxt, err_nxt;
    logic [RW-1:0]     rdata_nxt;
    logic              mreq_nxt, mwe_nxt, mlong_nxt;
    logic [RW-1:0]     maddr_nxt, mdata_nxt;
    logic [SELW-1:0]   msel_nxt;
    logic [7:0]        mhigh_nxt;

    assign elig = i_req & i_core_en;

    // Winner selection: rotating priority starting after the last grant, or lowest index.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        if (RR != 0) begin
            for (int k = 0; k < NCORES; k++) begin
                for (int i = 0; i < NCORES; i++) begin
                    if (!found && elig[i] && (i == (int'(last) + 1 + k) % NCORES)) begin
                        found = 1'b1;
                        pick  = GW'(i);
                    end
                end
            end
        end else begin
            for (int i = NCORES - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    pick = GW'(i);
                end
            end
        end
    end

    // Next-state and next-output computation; every output is taken from a register.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        cnt_nxt   = cnt;
        ack_nxt   = o_ack;
        err_nxt   = o_err;
        rdata_nxt = o_rdata;
        mreq_nxt  = o_mem_req;
        mwe_nxt   = o_mem_we;
        maddr_nxt = o_mem_addr;
        mdata_nxt = o_mem_data;
        msel_nxt  = o_mem_sel;
        mlong_nxt = o_mem_long;
        mhigh_nxt = o_mem_addr_high;
        case (state)
            IDLE: begin
                if (|elig) begin
                    grant_nxt = pick;
                    mreq_nxt  = 1'b1;
                    mwe_nxt   = i_we[pick];
                    maddr_nxt = i_addr[pick*RW +: RW];
                    mdata_nxt = i_wdata[pick*RW +: RW];
                    msel_nxt  = i_sel[pick*SELW +: SELW];
                    mlong_nxt = i_long[pick];
                    mhigh_nxt = i_addr_high[pick*8 +: 8];
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    mreq_nxt  = 1'b0;
                    ack_nxt   = NCORES'(1) << grant;
                    err_nxt   = NCORES'(i_mem_err) << grant;
                    rdata_nxt = i_mem_rdata;
                    // Only a real bus completion moves the round-robin pointer.
                    last_nxt  = grant;
                    state_nxt = DONE;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    mreq_nxt  = 1'b0;
                    ack_nxt   = NCORES'(1) << grant;
                    err_nxt   = NCORES'(1) << grant;
                    rdata_nxt = '0;
                    state_nxt = DONE;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                // One quiet cycle lets the core drop or renew its request.
                ack_nxt   = '0;
                err_nxt   = '0;
                rdata_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state: FSM, grant, round-robin pointer and timeout counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            grant <= '0;
            last  <= LAST_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered core-side and bus-side outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack           <= '0;
            o_err           <= '0;
            o_rdata         <= '0;
            o_mem_req       <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_data      <= '0;
            o_mem_sel       <= '0;
            o_mem_long      <= 1'b0;
            o_mem_addr_high <= '0;
        end else begin
            o_ack           <= ack_nxt;
            o_err           <= err_nxt;
            o_rdata         <= rdata_nxt;
            o_mem_req       <= mreq_nxt;
            o_mem_we        <= mwe_nxt;
            o_mem_addr      <= maddr_nxt;
            o_mem_data      <= mdata_nxt;
            o_mem_sel       <= msel_nxt;
            o_mem_long      <= mlong_nxt;
            o_mem_addr_high <= mhigh_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_dmem_arbiter
//  Description : Self-checking bench; a round-robin and a fixed-priority
//                instance share all inputs and are checked per transaction
//                against a reference model of the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_dmem_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  core_en, req, we, lng;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [15:0] addr_high;
    logic        mem_ack, mem_err;
    logic [15:0] mem_rdata;

    logic [1:0]  ack_a, err_a, ack_b, err_b;
    logic [15:0] rdata_a, rdata_b, maddr_a, maddr_b, mdata_a, mdata_b;
    logic        mreq_a, mreq_b, mwe_a, mwe_b, mlong_a, mlong_b;
    logic [1:0]  msel_a, msel_b;
    logic [7:0]  mhigh_a, mhigh_b;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          last_rr;
    logic        f_we[2], f_long[2];
    logic [15:0] f_addr[2], f_wdata[2];
    logic [1:0]  f_sel[2];
    logic [7:0]  f_high[2];

    always #5 clk = ~clk;

    core_dmem_arbiter #(.NCORES(2), .RW(16), .SELW(2), .RR(1), .TIMEOUT(TMO)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_core_en(core_en), .i_req(req), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .i_sel(sel), .i_long(lng), .i_addr_high(addr_high),
        .o_ack(ack_a), .o_err(err_a), .o_rdata(rdata_a), .o_mem_req(mreq_a), .o_mem_we(mwe_a),
        .o_mem_addr(maddr_a), .o_mem_data(mdata_a), .o_mem_sel(msel_a), .o_mem_long(mlong_a),
        .o_mem_addr_high(mhigh_a), .i_mem_ack(mem_ack), .i_mem_err(mem_err), .i_mem_rdata(mem_rdata));

    core_dmem_arbiter #(.NCORES(2), .RW(16), .SELW(2), .RR(0), .TIMEOUT(TMO)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n), .i_core_en(core_en), .i_req(req), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .i_sel(sel), .i_long(lng), .i_addr_high(addr_high),
        .o_ack(ack_b), .o_err(err_b), .o_rdata(rdata_b), .o_mem_req(mreq_b), .o_mem_we(mwe_b),
        .o_mem_addr(maddr_b), .o_mem_data(mdata_b), .o_mem_sel(msel_b), .o_mem_long(mlong_b),
        .o_mem_addr_high(mhigh_b), .i_mem_ack(mem_ack), .i_mem_err(mem_err), .i_mem_rdata(mem_rdata));

    task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [43:0] bus_a();
        return {mwe_a, maddr_a, mdata_a, msel_a, mlong_a, mhigh_a};
    endfunction

    function automatic logic [43:0] bus_b();
        return {mwe_b, maddr_b, mdata_b, msel_b, mlong_b, mhigh_b};
    endfunction

    function automatic logic [43:0] core_fields(input int c);
        return {f_we[c], f_addr[c], f_wdata[c], f_sel[c], f_long[c], f_high[c]};
    endfunction

    // Round-robin: first eligible core after the last completed grant, wrapping.
    function automatic int rr_pick(input logic [1:0] e, input int last);
        for (int k = 1; k <= 2; k++) begin
            if (e[(last + k) % 2]) return (last + k) % 2;
        end
        return -1;
    endfunction

    // Fixed priority: lowest eligible index.
    function automatic int fp_pick(input logic [1:0] e);
        return e[0] ? 0 : 1;
    endfunction

    // Randomise every core's request fields; a0 >= 0 forces core 0 to a read of that address.
    task automatic drive_fields(input int a0);
        for (int c = 0; c < 2; c++) begin
            f_we[c]    = 1'($urandom);
            f_long[c]  = 1'($urandom);
            f_addr[c]  = 16'($urandom);
            f_wdata[c] = 16'($urandom);
            f_sel[c]   = 2'($urandom);
            f_high[c]  = 8'($urandom);
        end
        if (a0 >= 0) begin
            f_addr[0] = 16'(a0);
            f_we[0]   = 1'b0;
        end
        we        = {f_we[1], f_we[0]};
        lng       = {f_long[1], f_long[0]};
        addr      = {f_addr[1], f_addr[0]};
        wdata     = {f_wdata[1], f_wdata[0]};
        sel       = {f_sel[1], f_sel[0]};
        addr_high = {f_high[1], f_high[0]};
    endtask

    // One transaction, entered 1 time unit after an edge with both instances idle.
    // dly = bus cycles before ack; dly >= TMO means the bus never answers.
    task automatic do_txn(input logic [1:0] en, input logic [1:0] rq, input int dly,
                          input logic berr, input logic [15:0] rdat, input int a0);
        logic [1:0]  elig;
        logic [43:0] exp_a, exp_b;
        int          wa, wb, n;
        bit          tmo;
        drive_fields(a0);
        core_en   = en;
        req       = rq;
        mem_ack   = 1'($urandom);
        mem_err   = 1'($urandom);
        mem_rdata = 16'($urandom);
        elig = rq & en;
        @(posedge clk); #1;
        if (elig == 2'b00) begin
            check_eq("idle_hold", {mreq_a, mreq_b, ack_a, ack_b}, '0);
            mem_ack = 1'b0;
            req     = 2'b00;
            return;
        end
        wa    = rr_pick(elig, last_rr);
        wb    = fp_pick(elig);
        exp_a = core_fields(wa);
        exp_b = core_fields(wb);
        check_eq("grant_bus_rr", bus_a(), exp_a);
        check_eq("grant_bus_fp", bus_b(), exp_b);
        drive_fields(-1);
        core_en = 2'($urandom);
        req     = 2'($urandom);
        tmo = (dly >= TMO);
        n   = tmo ? TMO : dly + 1;
        for (int c = 0; c < n; c++) begin
            check_eq("busy_req", {mreq_a, mreq_b, ack_a, ack_b}, {2'b11, 4'b0000});
            if (c == n - 1) begin
                check_eq("busy_hold_rr", bus_a(), exp_a);
                check_eq("busy_hold_fp", bus_b(), exp_b);
            end
            mem_ack   = (!tmo && c == dly);
            mem_err   = berr;
            mem_rdata = (!tmo && c == dly) ? rdat : 16'($urandom);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_err = 1'b0;
        end
        check_eq("done_rr", {mreq_a, ack_a, err_a, rdata_a},
                 {1'b0, 2'(1 << wa), (tmo || berr) ? 2'(1 << wa) : 2'b00, tmo ? 16'h0 : rdat});
        check_eq("done_fp", {mreq_b, ack_b, err_b, rdata_b},
                 {1'b0, 2'(1 << wb), (tmo || berr) ? 2'(1 << wb) : 2'b00, tmo ? 16'h0 : rdat});
        if (!tmo) last_rr = wa;
        // Late/stray acknowledge during the completion cycle must be ignored.
        mem_ack   = 1'b1;
        mem_err   = 1'b1;
        mem_rdata = 16'($urandom);
        req       = 2'b00;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_err = 1'b0;
        check_eq("after_done", {mreq_a, mreq_b, ack_a, ack_b, err_a, err_b, rdata_a, rdata_b}, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        core_en = 2'b00; req = 2'b00; mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        drive_fields(-1);
        last_rr = 1;
        #1;
        check_eq("reset_async", {ack_a, err_a, rdata_a, mreq_a, bus_a()}, '0);
        @(posedge clk); @(posedge clk); #1;
        check_eq("reset_rr", {ack_a, err_a, rdata_a, mreq_a, bus_a()}, '0);
        check_eq("reset_fp", {ack_b, err_b, rdata_b, mreq_b, bus_b()}, '0);
        rst_n = 1'b1;

        // Single read from core 0, ack in the 2nd bus cycle
        do_txn(2'b11, 2'b01, 1, 1'b0, 16'hBEEF, 16'h1234);
        // Fairness: both requesting continuously
        for (int i = 0; i < 4; i++) do_txn(2'b11, 2'b11, 0, 1'b0, 16'($urandom), -1);
        // Timeout with no ack
        do_txn(2'b11, 2'b10, 20, 1'b0, 16'h0, -1);
        // Bus error on a core 1 transfer
        do_txn(2'b11, 2'b10, 0, 1'b1, 16'h5A5A, -1);
        // Enable mask, then core 0 re-enabled
        do_txn(2'b10, 2'b11, 2, 1'b0, 16'h0101, -1);
        do_txn(2'b11, 2'b11, 0, 1'b0, 16'h0202, -1);

        // Reset in the middle of a bus transfer
        core_en = 2'b11; req = 2'b11;
        @(posedge clk); #1;
        check_eq("pre_reset_busy", {mreq_a, mreq_b}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset_mid_rr", {ack_a, err_a, rdata_a, mreq_a, bus_a()}, '0);
        check_eq("reset_mid_fp", {ack_b, err_b, rdata_b, mreq_b, bus_b()}, '0);
        @(posedge clk); @(posedge clk); #1;
        check_eq("reset_no_ack", {ack_a, ack_b, mreq_a, mreq_b}, '0);
        last_rr = 1;
        rst_n = 1'b1;
        do_txn(2'b11, 2'b11, 0, 1'b0, 16'h7777, -1);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            do_txn(($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11,
                   2'($urandom_range(0, 3)), int'($urandom_range(0, 11)),
                   1'($urandom), 16'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so a wedged run still terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
